// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU program sequencer: instruction classes,
// FSM states and instruction-word field positions.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    CL_LOAD = 2'b00,
    CL_EXEC = 2'b01,
    CL_LOOP = 2'b10,
    CL_HALT = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT
  } state_e;

  localparam int unsigned CLS_HI   = 15;
  localparam int unsigned CLS_LO   = 14;
  localparam int unsigned CIN_BIT  = 13;
  localparam int unsigned COUT_BIT = 12;
  localparam int unsigned REG_HI   = 10;
  localparam int unsigned REG_LO   = 8;
  localparam int unsigned DATA_HI  = 7;
  localparam int unsigned DATA_LO  = 0;
  localparam int unsigned OP_HI    = 3;
  localparam int unsigned OP_LO    = 0;
  localparam int unsigned CNT_HI   = 7;
  localparam int unsigned CNT_LO   = 4;
  localparam int unsigned TGT_HI   = 3;
  localparam int unsigned TGT_LO   = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Host programming bus and datapath strobe bus of the ALU sequencer.
interface alu_seq_if #(
  parameter int unsigned AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          dp_ce;
  logic          dp_load;
  logic [7:0]    dp_opcode;
  logic [7:0]    dp_data;
  logic          dp_cin;
  logic          dp_cout;

  modport master (
    output prog_we, prog_addr, prog_data,
    input  dp_ce, dp_load, dp_opcode, dp_data, dp_cin, dp_cout
  );

  modport slave (
    input  prog_we, prog_addr, prog_data,
    output dp_ce, dp_load, dp_opcode, dp_data, dp_cin, dp_cout
  );
endinterface

// File: rtl/alu_seq_imem.sv
// Instruction buffer: single write port, synchronous read into the
// instruction register (the register resets, the array does not).
module alu_seq_imem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);
  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/alu_sequencer.sv
// Program sequencer: fetches instructions from the buffer and drives the
// datapath strobes, with one hardware loop, HALT and run-off detection.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned OP_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_if.slave      bus,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc
);
  localparam int unsigned WW = (OP_LAT < 2) ? 1 : $clog2(OP_LAT + 1);

  state_e        state, state_n;
  logic [AW-1:0] pc_n;
  logic [3:0]    lc, lc_n;
  logic          lact, lact_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic          done_n, err_n, fetch;
  logic          step;
  state_e        step_to;
  logic [15:0]   ir;
  cls_e          cls;
  logic [AW-1:0] tgt;
  logic [3:0]    cnt;
  logic          ce, load, cin, cout;
  logic [7:0]    opcode, data;
  logic          unused_ir11;

  assign busy        = (state != IDLE);
  assign cls         = cls_e'(ir[CLS_HI:CLS_LO]);
  assign tgt         = AW'(ir[TGT_HI:TGT_LO]);
  assign cnt         = ir[CNT_HI:CNT_LO];
  assign unused_ir11 = ir[11];

  alu_seq_imem #(.DEPTH(DEPTH), .AW(AW)) u_imem (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.prog_we & ~busy),
    .wr_addr (bus.prog_addr),
    .wr_data (bus.prog_data),
    .rd_en   (fetch),
    .rd_addr (pc),
    .rd_data (ir)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      lc    <= '0;
      lact  <= 1'b0;
      wcnt  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      lc    <= lc_n;
      lact  <= lact_n;
      wcnt  <= wcnt_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    lc_n    = lc;
    lact_n  = lact;
    wcnt_n  = wcnt;
    done_n  = 1'b0;
    err_n   = err;
    fetch   = 1'b0;
    step    = 1'b0;
    step_to = FETCH;
    ce      = 1'b0;
    load    = 1'b0;
    opcode  = '0;
    data    = '0;
    cin     = 1'b0;
    cout    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          // A stale loop from an aborted run must not leak into the next one.
          pc_n    = '0;
          err_n   = 1'b0;
          lc_n    = '0;
          lact_n  = 1'b0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        fetch   = 1'b1;
        state_n = ISSUE;
      end
      ISSUE: begin
        unique case (cls)
          CL_LOAD: begin
            ce     = 1'b1;
            load   = 1'b1;
            opcode = {1'b0, ir[REG_HI:REG_LO], 4'b0000};
            data   = ir[DATA_HI:DATA_LO];
            step   = 1'b1;
          end
          CL_EXEC: begin
            ce      = 1'b1;
            opcode  = {1'b0, ir[REG_HI:REG_LO], ir[OP_HI:OP_LO]};
            cin     = ir[CIN_BIT];
            cout    = ir[COUT_BIT];
            wcnt_n  = WW'(OP_LAT);
            step    = 1'b1;
            step_to = (OP_LAT == 0) ? FETCH : WAIT;
          end
          CL_LOOP: begin
            state_n = FETCH;
            if (!lact) begin
              if (cnt == 4'd0) begin
                step = 1'b1;
              end else begin
                lc_n   = cnt;
                lact_n = 1'b1;
                pc_n   = tgt;
              end
            end else begin
              lc_n = lc - 4'd1;
              if (lc != 4'd1) begin
                pc_n = tgt;
              end else begin
                lact_n = 1'b0;
                step   = 1'b1;
              end
            end
          end
          CL_HALT: begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        endcase
      end
      WAIT: begin
        wcnt_n = wcnt - WW'(1);
        if (wcnt <= WW'(1)) state_n = FETCH;
      end
    endcase

    // Sequential advance: stepping past the last entry terminates with err.
    if (step) begin
      if (pc == AW'(DEPTH - 1)) begin
        err_n   = 1'b1;
        done_n  = 1'b1;
        state_n = IDLE;
      end else begin
        pc_n    = pc + AW'(1);
        state_n = step_to;
      end
    end

    if (abort) begin
      state_n = IDLE;
      pc_n    = pc;
      lc_n    = lc;
      lact_n  = lact;
      wcnt_n  = wcnt;
      err_n   = err;
      done_n  = 1'b0;
      fetch   = 1'b0;
      ce      = 1'b0;
    end
  end

  assign bus.dp_ce     = ce;
  assign bus.dp_load   = load;
  assign bus.dp_opcode = opcode;
  assign bus.dp_data   = data;
  assign bus.dp_cin    = cin;
  assign bus.dp_cout   = cout;
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Program sequencer for the 8-register/ALU datapath. A host preloads a 16-entry instruction buffer. After `start`, the block fetches and decodes each instruction and drives the datapath's `ce`/`load`/`opcode`/`data_in`/`cin`/`cout` inputs. It waits the datapath's fixed operation latency between ALU operations and supports one hardware loop and `HALT`. It replaces direct host control of the datapath strobes.

## Interface

**Parameters**
- `DEPTH`, default 16: instruction entries. Must be a power of two.
- `AW`, default 4: instruction address width, log2(`DEPTH`).
- `OP_LAT`, default 3: idle cycles after an EXEC issue before the next fetch. Equals the datapath's issue-to-writeback-to-ready time.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `prog_we`, in, 1: instruction write strobe. Honoured only when `busy`=0.
- `prog_addr`, in, `AW`: instruction write address.
- `prog_data`, in, 16: instruction word.
- `start`, in, 1: begin execution at pc 0. Honoured only when `busy`=0.
- `abort`, in, 1: stop execution.
- `busy`, out, 1: a program is running.
- `done`, out, 1: one-cycle pulse on HALT or on running off the end of the buffer.
- `err`, out, 1: sticky. Set when the program runs past entry `DEPTH`-1. Cleared by `start`.
- `pc`, out, `AW`: current instruction address.
- `dp_ce`, out, 1: datapath enable.
- `dp_load`, out, 1: datapath load select.
- `dp_opcode`, out, 8: bit 7 = 0, bits [6:4] = register, bits [3:0] = ALU operation.
- `dp_data`, out, 8: load data.
- `dp_cin`, out, 1: carry-in flag to the datapath.
- `dp_cout`, out, 1: carry-out flag to the datapath.

## Operation

**Instruction word.** `class` = bits [15:14].
- `00` LOAD: reg = [10:8], data = [7:0].
- `01` EXEC: cin = [13], cout = [12], reg = [10:8], op = [3:0].
- `10` LOOP: count = [7:4], target = [3:0].
- `11` HALT.

**States**
- IDLE
  - `start` (and no `abort`) sets pc=0, clears `err`, and moves to FETCH.
- FETCH
  - Synchronous read of mem[pc] into `ir`. Next state is ISSUE.
- ISSUE, decoded from `ir`:
  - LOAD: `dp_ce`=1, `dp_load`=1, `dp_opcode`={0,reg,0000}, `dp_data`=data. Then pc+1, FETCH.
  - EXEC: `dp_ce`=1, `dp_load`=0, `dp_opcode`={0,reg,op}, `dp_cin`/`dp_cout` from the instruction. Then pc+1, WAIT with wcnt=`OP_LAT`.
  - LOOP, using loop counter `lc` and flag `lact`:
    - `lact`=0 and count=0: no-op, pc+1.
    - `lact`=0 and count≠0: `lc`=count, `lact`=1, pc=target.
    - `lact`=1: `lc`=`lc`-1. If the result is ≠0, pc=target; otherwise `lact`=0 and pc+1.
    - The loop body therefore executes count+1 times. Nesting is not supported; an inner LOOP shares `lc`.
    - Next state is FETCH.
  - HALT: move to IDLE and pulse `done`.
- WAIT
  - Decrement wcnt. When it reaches 0, move to FETCH.
- End of buffer
  - A pc increment out of entry `DEPTH`-1 (not HALT) sets `err`=1, pulses `done`, and moves to IDLE. pc does not wrap.
  - A LOOP target always stays within the buffer.

**Datapath outputs**
- `dp_*` outputs are all 0 outside ISSUE.
- `dp_ce` is high for exactly one cycle per LOAD or EXEC.

**Control**
- `abort` in any state moves to IDLE on the next edge. It forces `dp_ce`=0, produces no `done`, and leaves `err` unchanged.
- `abort` and `start` together: `abort` wins.
- `prog_we` while `busy`=1 is ignored; memory is unchanged.
- `start` while busy is ignored.

## Timing

**Reset values**
- State IDLE.
- `busy`, `done`, `err`, `pc`, `lc`, `lact`, `ir`, and all `dp_*` outputs = 0.
- Instruction memory is not reset.
- Reset mid-operation drops any in-flight issue; `dp_ce` is low immediately (asynchronous).

**Status outputs**
- `busy` = (state ≠ IDLE).
- `done` is registered, high in the first IDLE cycle after termination.

**Per-instruction cost**
- LOAD: 2 cycles.
- LOOP: 2 cycles.
- EXEC: 2+`OP_LAT` cycles.
- HALT: 2 cycles, then `done`.

## Structure

- Package `alu_seq_pkg`:
  - Class encodings: `CL_LOAD`, `CL_EXEC`, `CL_LOOP`, `CL_HALT`.
  - State enum: IDLE, FETCH, ISSUE, WAIT.
  - Instruction field bit positions.
- Sub-module `alu_seq_imem`:
  - `DEPTH`×16 single-port-write / single-port-read RAM.
  - Synchronous read, write gated by `prog_we & ~busy`.
- Top level holds the FSM, pc, `lc`/`lact`, the wait counter, and the output decode.

## Test plan

- **Basic program.** Program: LOAD r1=0x05; LOAD r0=0x03; EXEC reg1 op2 cin0; HALT. `start` is sampled at edge 0.
  - `dp_ce` is high in cycles 2, 4 and 6 with `dp_opcode` 0x10, 0x00, 0x12 and `dp_data` 0x05, 0x03, 0x00.
  - `done`=1 in cycle 12 only, `err`=0.
- **Loop.** Program: EXEC r1 op0; LOOP count=3, target=0; HALT.
  - Exactly 4 `dp_ce` pulses, each followed by 3 idle cycles before the next FETCH.
  - `done` follows, `lact`=0 at the end.
- **Run-off.** No HALT, all 16 entries LOAD.
  - 16 `dp_ce` pulses, then `done`=1 and `err`=1.
  - A following `start` clears `err`.
- **Abort in WAIT.** `abort` asserted in the 2nd WAIT cycle.
  - `busy`=0 on the next cycle, no `done`, no further `dp_ce`.
  - `abort`+`start` together in IDLE leaves `busy` at 0.
- **Writes while busy.** `prog_we` to address 0 with 0xFFFF while busy is ignored; re-running reproduces the original `dp_*` sequence.
- **Async reset.** `rst` pulsed mid-EXEC during ISSUE drops `dp_ce` asynchronously; all outputs read 0.
